bridge_uart_tx: RTL and testbench

Read-response transmitter for the host bridge. It accepts a 16-bit read result from the bus side and serialises it as a 7-byte ASCII frame: 'M', four uppercase hex digits (MSB nibble first), CR, LF. The frame goes out over an 8N1 UART line. It sits between the core's bus-response path and the FPGA TX pin, and pairs with the bridge receive path.

---
 rtl/bridge_pkg.sv | 50 +++++
 rtl/bridge_uart_tx_uart.sv | 112 +++++++++++
 rtl/bridge_uart_tx.sv | 97 +++++++++
 tb/tb_bridge_uart_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types, frame constants and the nibble-to-ASCII helper
// for the bridge read-response transmitter.
`timescale 1ns/1ps
package bridge_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'h4D;
  localparam logic [7:0] CR           = 8'h0D;
  localparam logic [7:0] LF           = 8'h0A;
  localparam int         FRAME_LEN    = 7;

  typedef enum logic [1:0] {
    B_IDLE,
    B_SEND,
    B_DRAIN
  } bridge_state_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nib2asc(
    input logic [3:0] n
  );
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return 8'h37 + {4'h0, n};
  endfunction

  // Byte idx of the frame 'M' h h h h CR LF.
  function automatic logic [7:0] frame_byte(
    input logic [15:0] d,
    input logic [2:0]  idx
  );
    case (idx)
      3'd0:    return FRAME_HEADER;
      3'd1:    return nib2asc(d[15:12]);
      3'd2:    return nib2asc(d[11:8]);
      3'd3:    return nib2asc(d[7:4]);
      3'd4:    return nib2asc(d[3:0]);
      3'd5:    return CR;
      default: return LF;
    endcase
  endfunction

endpackage

// File: rtl/bridge_uart_tx_uart.sv
// 8N1 UART transmitter (module uart_tx).
// Ports: clk, rst, data/valid/ready byte input, busy, tx line.
`timescale 1ns/1ps
module uart_tx
  import bridge_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int CW =
    (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [CW-1:0] BIT_LAST =
    CW'(CLOCKS_PER_BAUD - 1);
  // The idle cycle that follows STOP is the last
  // cycle of the stop bit, which lets the next
  // byte start without a gap while ready stays
  // tied to the idle state.
  localparam logic [CW-1:0] STOP_LAST =
    CW'(CLOCKS_PER_BAUD - 2);

  uart_state_e   r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_sh, w_sh_nx;
  logic          r_tx, w_tx_nx;
  logic          r_tail, w_tail_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= U_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
      r_tail  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_sh    <= w_sh_nx;
      r_tx    <= w_tx_nx;
      r_tail  <= w_tail_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_sh_nx    = r_sh;
    w_tx_nx    = r_tx;
    w_tail_nx  = 1'b0;
    unique case (r_state)
      U_IDLE: begin
        if (valid) begin
          w_sh_nx    = data;
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
          w_tx_nx    = 1'b0;
          w_state_nx = U_START;
        end
      end
      U_START: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nx   = '0;
          w_tx_nx    = r_sh[0];
          w_state_nx = U_DATA;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      U_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nx = '0;
          if (r_bit == 3'd7) begin
            w_tx_nx    = 1'b1;
            w_state_nx = U_STOP;
          end else begin
            w_bit_nx = r_bit + 3'd1;
            w_sh_nx  = r_sh >> 1;
            w_tx_nx  = r_sh[1];
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      U_STOP: begin
        if (r_cnt == STOP_LAST) begin
          w_cnt_nx   = '0;
          w_tail_nx  = 1'b1;
          w_state_nx = U_IDLE;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = U_IDLE;
    endcase
  end

  assign ready = (r_state == U_IDLE);
  assign busy  = (r_state != U_IDLE) || r_tail;
  assign tx    = r_tx;

endmodule

// File: rtl/bridge_uart_tx.sv
// Sends a 16-bit read result as "Mhhhh\r\n" over 8N1.
// Ports: clk, rst, rdata_i, rw_i, valid_i in; busy_o, tx out.
`timescale 1ns/1ps
module bridge_uart_tx
  import bridge_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        busy_o,
  output logic        tx
);

  bridge_state_e r_state, w_state_nx;
  logic [15:0]   r_data, w_data_nx;
  logic [2:0]    r_idx, w_idx_nx;
  logic          r_uv, w_uv_nx;
  logic [7:0]    r_ub, w_ub_nx;
  logic          w_uready;
  logic          w_ubusy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= B_IDLE;
      r_data  <= '0;
      r_idx   <= '0;
      r_uv    <= 1'b0;
      r_ub    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_data  <= w_data_nx;
      r_idx   <= w_idx_nx;
      r_uv    <= w_uv_nx;
      r_ub    <= w_ub_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_data_nx  = r_data;
    w_idx_nx   = r_idx;
    w_uv_nx    = r_uv;
    w_ub_nx    = r_ub;
    unique case (r_state)
      B_IDLE: begin
        w_uv_nx = 1'b0;
        if (valid_i && rw_i) begin
          w_data_nx  = rdata_i;
          w_idx_nx   = '0;
          w_state_nx = B_SEND;
        end
      end
      B_SEND: begin
        // Next byte is staged while the UART is
        // still shifting, so it is waiting in the
        // UART's idle cycle and bytes are gapless.
        if (r_uv) begin
          if (w_uready) begin
            w_uv_nx  = 1'b0;
            w_idx_nx = r_idx + 3'd1;
            if (r_idx == 3'(FRAME_LEN - 1))
              w_state_nx = B_DRAIN;
          end
        end else begin
          w_uv_nx = 1'b1;
          w_ub_nx = frame_byte(r_data, r_idx);
        end
      end
      B_DRAIN: begin
        if (!w_ubusy) begin
          w_idx_nx   = '0;
          w_state_nx = B_IDLE;
        end
      end
      default: w_state_nx = B_IDLE;
    endcase
  end

  uart_tx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_uart (
    .clk   (clk),
    .rst   (rst),
    .data  (r_ub),
    .valid (r_uv),
    .ready (w_uready),
    .busy  (w_ubusy),
    .tx    (tx)
  );

  assign busy_o = (r_state != B_IDLE);

endmodule

// File: tb/tb_bridge_uart_tx.sv
// Randomised frame checks for bridge_uart_tx against
// a bit-level model of the ASCII frame on the line.
`timescale 1ns/1ps
module tb_bridge_uart_tx;

  localparam int CPB = 8;
  localparam int FBITS = 70;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rdata_i;
  logic        rw_i;
  logic        valid_i;
  logic        busy_o;
  logic        tx;

  int n_chk  = 0;
  int n_pass = 0;

  bridge_uart_tx #(
    .CLOCKS_PER_BAUD(CPB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rdata_i (rdata_i),
    .rw_i    (rw_i),
    .valid_i (valid_i),
    .busy_o  (busy_o),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
  endtask

  function automatic logic [7:0] hex_ch(
    input int n
  );
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  task automatic idle_chk(
    input string tag,
    input int    n
  );
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy_o !== 1'b0)
        bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic run_frame(
    input logic [15:0] d,
    input int          poke_at,
    input int          rst_at
  );
    logic [7:0] eb [7];
    logic [7:0] gb [7];
    int bad, b, k, pos;
    logic e;
    bad = 0;
    eb[0] = 8'h4D;
    for (int i = 0; i < 4; i++)
      eb[i+1] = hex_ch((int'(d) >> (12 - 4*i)) % 16);
    eb[5] = 8'h0D;
    eb[6] = 8'h0A;
    for (int i = 0; i < 7; i++) gb[i] = 8'h00;
    @(negedge clk);
    rdata_i = d;
    rw_i    = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    rdata_i = 16'h0;
    chk("busy_rise", busy_o, 1);
    @(negedge clk);
    chk("pre_start", tx, 1);
    for (int j = 0; j < FBITS*CPB; j++) begin
      @(negedge clk);
      if (rst_at >= 0 && j == rst_at + 1) begin
        rst = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy_o, 0);
        return;
      end
      b   = j / CPB;
      k   = b / 10;
      pos = b % 10;
      if (pos == 0)      e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else               e = eb[k][pos-1];
      if (tx !== e) bad++;
      if (j % CPB == CPB/2 && pos >= 1 && pos <= 8)
        gb[k][pos-1] = tx;
      if (j == poke_at) begin
        rdata_i = 16'hFFFF;
        rw_i    = 1'b1;
        valid_i = 1'b1;
      end
      if (j == poke_at + 1) valid_i = 1'b0;
      if (j == rst_at) rst = 1'b1;
    end
    for (int i = 0; i < 7; i++)
      chk($sformatf("byte%0d_%h", i, d), gb[i], eb[i]);
    chk("wave_err", bad, 0);
    @(negedge clk);
    chk("busy_tail", busy_o, 1);
    chk("stop_tx", tx, 1);
    @(negedge clk);
    chk("busy_fall", busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    rdata_i = 16'h0;
    rw_i    = 1'b0;
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy_o, 0);
    rst = 1'b0;

    @(negedge clk);
    rst     = 1'b1;
    rdata_i = 16'h1234;
    rw_i    = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b0;
    chk("rst_wins", busy_o, 0);
    idle_chk("rst_wins_idle", 20*CPB);

    run_frame(16'h0123, -1, -1);
    run_frame(16'h89AB, -1, -1);
    run_frame(16'hCDEF, -1, -1);

    @(negedge clk);
    rdata_i = 16'h4567;
    rw_i    = 1'b0;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    idle_chk("write_ignored", 250*CPB);

    run_frame(16'h0123, 35*CPB, -1);
    idle_chk("no_second", 30*CPB);

    run_frame(16'h0123, -1, 23*CPB);
    idle_chk("after_rst", 20*CPB);
    run_frame(16'h4567, -1, -1);

    for (int r = 0; r < 4; r++)
      run_frame(16'($urandom), -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
